// File: rtl/ex_stage.sv
// ex_stage: execute stage of the 5-stage RISC-V pipeline.
//
// Takes the ID/EX register outputs, forwards rs1/rs2 from EX/MEM (this
// block's own output register) or from MEM/WB, runs the ALU, resolves
// conditional branches and computes the branch target. Results are stored
// in the built-in EX/MEM register, which supports stall and flush.
//
// Ports:
//   clk, res           clock (rising edge), async active-low reset
//   stall, flush       hold / bubble the EX/MEM register (flush wins)
//   *_in               ID/EX control bits, PC, func3/func7/opcode,
//                      operands, register indices, immediate
//   WB_RegWrite/RD/data  MEM/WB writeback, used for forwarding
//   PCSrc, branch_target combinational branch decision and target
//   *_out              registered EX/MEM control and data
module ex_stage #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            res,
    input  logic            stall,
    input  logic            flush,
    input  logic            RegWrite_in,
    input  logic            MemtoReg_in,
    input  logic            MemRead_in,
    input  logic            MemWrite_in,
    input  logic            Branch_in,
    input  logic            ALUSrc_in,
    input  logic [1:0]      ALUop_in,
    input  logic [XLEN-1:0] PC_in,
    input  logic [2:0]      func3_in,
    input  logic [6:0]      func7_in,
    input  logic [6:0]      OPCODE_in,
    input  logic [XLEN-1:0] ALU_A_in,
    input  logic [XLEN-1:0] ALU_B_in,
    input  logic [4:0]      RS1_in,
    input  logic [4:0]      RS2_in,
    input  logic [4:0]      RD_in,
    input  logic [XLEN-1:0] IMM_in,
    input  logic            WB_RegWrite,
    input  logic [4:0]      WB_RD,
    input  logic [XLEN-1:0] WB_data,
    output logic            PCSrc,
    output logic [XLEN-1:0] branch_target,
    output logic            RegWrite_out,
    output logic            MemtoReg_out,
    output logic            MemRead_out,
    output logic            MemWrite_out,
    output logic [XLEN-1:0] ALU_result_out,
    output logic [XLEN-1:0] store_data_out,
    output logic [4:0]      RD_out,
    output logic [2:0]      func3_out
);

    localparam logic [6:0] OP_RTYPE = 7'b0110011;

    // Only func7[5] participates in decode.
    logic unused_func7;
    assign unused_func7 = ^{func7_in[6], func7_in[4:0]};

    logic [XLEN-1:0] fwd_a;
    logic [XLEN-1:0] fwd_b;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] alu_res;
    logic [4:0]      shamt;
    logic            cond;
    logic            exmem_fwd_ok;

    // A load in EX/MEM has no data yet; load-use is stalled upstream, so
    // such a match simply falls through to MEM/WB or the register file.
    assign exmem_fwd_ok = RegWrite_out && !MemRead_out && (RD_out != 5'd0);

    always_comb begin
        fwd_a = ALU_A_in;
        if (exmem_fwd_ok && (RD_out == RS1_in))
            fwd_a = ALU_result_out;
        else if (WB_RegWrite && (WB_RD != 5'd0) && (WB_RD == RS1_in))
            fwd_a = WB_data;
    end

    always_comb begin
        fwd_b = ALU_B_in;
        if (exmem_fwd_ok && (RD_out == RS2_in))
            fwd_b = ALU_result_out;
        else if (WB_RegWrite && (WB_RD != 5'd0) && (WB_RD == RS2_in))
            fwd_b = WB_data;
    end

    assign op_b  = ALUSrc_in ? IMM_in : fwd_b;
    assign shamt = op_b[4:0];

    always_comb begin
        alu_res = '0;
        unique case (ALUop_in)
            2'b00: alu_res = fwd_a + op_b;
            2'b01: alu_res = fwd_a - op_b;
            2'b11: alu_res = op_b;
            default: begin
                unique case (func3_in)
                    3'b000: alu_res = ((OPCODE_in == OP_RTYPE) && func7_in[5])
                                      ? fwd_a - op_b : fwd_a + op_b;
                    3'b001: alu_res = fwd_a << shamt;
                    3'b010: alu_res = {{(XLEN-1){1'b0}}, $signed(fwd_a) < $signed(op_b)};
                    3'b011: alu_res = {{(XLEN-1){1'b0}}, fwd_a < op_b};
                    3'b100: alu_res = fwd_a ^ op_b;
                    3'b101: alu_res = func7_in[5] ? XLEN'($signed(fwd_a) >>> shamt)
                                                  : fwd_a >> shamt;
                    3'b110: alu_res = fwd_a | op_b;
                    default: alu_res = fwd_a & op_b;
                endcase
            end
        endcase
    end

    always_comb begin
        cond = 1'b0;
        case (func3_in)
            3'b000: cond = (fwd_a == fwd_b);
            3'b001: cond = (fwd_a != fwd_b);
            3'b100: cond = ($signed(fwd_a) <  $signed(fwd_b));
            3'b101: cond = ($signed(fwd_a) >= $signed(fwd_b));
            3'b110: cond = (fwd_a <  fwd_b);
            3'b111: cond = (fwd_a >= fwd_b);
            default: cond = 1'b0;
        endcase
    end

    assign PCSrc         = res && Branch_in && cond && !flush;
    assign branch_target = PC_in + IMM_in;

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            RegWrite_out   <= 1'b0;
            MemtoReg_out   <= 1'b0;
            MemRead_out    <= 1'b0;
            MemWrite_out   <= 1'b0;
            ALU_result_out <= '0;
            store_data_out <= '0;
            RD_out         <= '0;
            func3_out      <= '0;
        end else if (flush) begin
            // Bubble: kill control, leave data as-is.
            RegWrite_out   <= 1'b0;
            MemtoReg_out   <= 1'b0;
            MemRead_out    <= 1'b0;
            MemWrite_out   <= 1'b0;
        end else if (!stall) begin
            RegWrite_out   <= RegWrite_in;
            MemtoReg_out   <= MemtoReg_in;
            MemRead_out    <= MemRead_in;
            MemWrite_out   <= MemWrite_in;
            ALU_result_out <= alu_res;
            store_data_out <= fwd_b;
            RD_out         <= RD_in;
            func3_out      <= func3_in;
        end
    end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage RISC-V pipeline. Sits directly downstream of the ID/EX pipeline register and consumes its outputs.
- Forwards operands from EX/MEM and MEM/WB, runs the ALU, resolves conditional branches and computes the branch target.
- Registers results into the EX/MEM pipeline register, which is built into this block and supports stall and flush.

Parameters:
XLEN, 32, datapath width; only 32 is supported.

Ports:
clk  input  1  clock, rising edge
res  input  1  reset, asynchronous, active-low
stall  input  1  hold the EX/MEM register
flush  input  1  load a bubble into the EX/MEM register
RegWrite_in, MemtoReg_in, MemRead_in, MemWrite_in, Branch_in, ALUSrc_in  input  1 each  control bits from ID/EX
ALUop_in  input  2  00 add, 01 branch compare, 10 decode by func3/func7, 11 pass operand B
PC_in  input  32  instruction PC
func3_in  input  3  instruction func3
func7_in  input  7  instruction func7
OPCODE_in  input  7  instruction opcode
ALU_A_in  input  32  rs1 data from ID/EX
ALU_B_in  input  32  rs2 data from ID/EX
RS1_in, RS2_in, RD_in  input  5 each  register indices
IMM_in  input  32  sign-extended immediate (byte offset for branches)
WB_RegWrite  input  1  MEM/WB write enable
WB_RD  input  5  MEM/WB destination register
WB_data  input  32  MEM/WB writeback value
PCSrc  output  1  combinational; branch taken this cycle
branch_target  output  32  combinational; PC_in+IMM_in
RegWrite_out, MemtoReg_out, MemRead_out, MemWrite_out  output  1 each  registered control bits
ALU_result_out  output  32  registered ALU result
store_data_out  output  32  registered forwarded rs2
RD_out  output  5  registered destination register
func3_out  output  3  registered func3 (memory access size)

Behaviour:
- Reset (res=0, async): every registered output is 0. PCSrc is 0 while res=0.
- Forwarding for operand A (rs1) and operand B (rs2) is evaluated independently.
  - Priority 1: EX/MEM when RegWrite_out=1, MemRead_out=0, RD_out!=0 and RD_out matches the register index. Forwards ALU_result_out.
  - Priority 2: MEM/WB when WB_RegWrite=1, WB_RD!=0 and WB_RD matches. Forwards WB_data.
  - Otherwise use ALU_A_in / ALU_B_in.
  - Index 0 never forwards. Load-use hazards are stalled upstream.
- ALU inputs:
  - opA is the forwarded rs1.
  - opB is IMM_in if ALUSrc_in=1, else the forwarded rs2.
  - store_data is always the forwarded rs2.
- ALUop decode:
  - 00: ADD.
  - 01: SUB.
  - 11: result = opB.
  - 10, by func3: 000 ADD, or SUB when OPCODE=0110011 and func7[5]=1; 001 SLL; 010 SLT (signed); 011 SLTU; 100 XOR; 101 SRL, or SRA when func7[5]=1; 110 OR; 111 AND.
  - Shift amount is opB[4:0]. All arithmetic wraps modulo 2^32.
- Branch resolution:
  - cond compares forwarded rs1 against forwarded rs2 by func3: 000 eq, 001 ne, 100 lt signed, 101 ge signed, 110 ltu, 111 geu. Other func3 values give cond=0.
  - PCSrc = Branch_in & cond & ~flush.
  - branch_target = PC_in + IMM_in, combinational, with no latency.
- EX/MEM register, on the rising edge, in priority order:
  - flush=1: control outputs go to 0; data outputs hold.
  - else stall=1: all outputs hold.
  - else: load the computed values. Latency is one cycle from ID/EX output to EX/MEM output.
- Simultaneous flush and stall: flush wins.
- Forwarding from EX/MEM during a stall uses the held values.

Test Plan:
1. res pulsed low mid-cycle with ALU_A_in=5 loaded -> all outputs become 0 immediately, asynchronously, before the next clk edge.
2. R-type SUB (ALUop=10, OPCODE=0110011, func3=000, func7=0100000), A=10, B=3 -> ALU_result_out=7 one cycle later. Same operands with func7=0 -> 13.
3. Back-to-back forwarding: instruction 1 writes x5=0x20. Instruction 2 reads rs1=x5 with stale ALU_A_in=0, ADD with IMM 4, ALUSrc=1 -> result 0x24. With WB_RD=5, WB_data=0x99 also active, EX/MEM priority is kept (result still 0x24).
4. BLT, forwarded rs1=-1, rs2=1, PC_in=0x100, IMM_in=-8 -> PCSrc=1, branch_target=0xF8. Same operands with BLTU -> PCSrc=0.
5. SRA with A=0x80000000, B=4 -> 0xF8000000. SRL with same operands -> 0x08000000.
6. stall=1 for 2 cycles then flush=1 with stall=1 -> outputs hold through the stall, then RegWrite_out and MemWrite_out are 0 after the flush edge.
